// File: rtl/parity_mem_ctrl.sv
// Parity-protected single-port memory with one even-parity bit per data lane.
// Tracks written entries, flags conflicts and bad addresses, and counts errors.
module parity_mem_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned NPAR  = DATA_W / LANE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write,
    input  logic                   read,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   inj_err,
    input  logic                   clr_count,
    output logic [DATA_W+NPAR-1:0] data_out,
    output logic                   rd_valid,
    output logic                   par_err,
    output logic                   uninit,
    output logic                   addr_err,
    output logic                   conflict,
    output logic [CNT_W-1:0]       error_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WORD_W = DATA_W + NPAR;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    function automatic logic [NPAR-1:0] lane_par(input logic [DATA_W-1:0] d);
        logic [NPAR-1:0] p;
        p = '0;
        for (int i = 0; i < int'(NPAR); i++) begin
            p[i] = ^d[i*LANE_W +: LANE_W];
        end
        return p;
    endfunction

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic [WORD_W-1:0] data_out_q;
    logic              rd_valid_q, par_err_q, uninit_q, addr_err_q, conflict_q;
    logic [CNT_W-1:0]  count_q;

    logic              in_range, do_write, do_read, rd_hit;
    logic              conflict_d, addr_err_d, par_err_d, uninit_d, err_any_d;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] rd_word, wr_word;

    always_comb begin
        in_range   = {1'b0, address} < DEPTH_A;
        idx        = address[IDX_W-1:0];
        conflict_d = write & read;
        // Conflict outranks a bad address, so only single-strobe accesses raise addr_err.
        addr_err_d = (write ^ read) & ~in_range;
        do_write   = write & ~read & in_range & ~rst;
        do_read    = read & ~write & in_range;
        rd_word    = mem_q[idx];
        rd_hit     = valid_q[idx];
        par_err_d  = do_read & rd_hit &
                     (lane_par(rd_word[DATA_W-1:0]) != rd_word[DATA_W +: NPAR]);
        uninit_d   = do_read & ~rd_hit;
        err_any_d  = conflict_d | addr_err_d | par_err_d;
        wr_word    = {lane_par(data_in) ^ NPAR'(inj_err), data_in};
    end

    // Storage is deliberately left out of reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            uninit_q   <= 1'b0;
            addr_err_q <= 1'b0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (do_write) begin
                valid_q[idx] <= 1'b1;
            end
            if (do_read) begin
                data_out_q <= rd_hit ? rd_word : '0;
            end
            rd_valid_q <= do_read;
            par_err_q  <= par_err_d;
            uninit_q   <= uninit_d;
            addr_err_q <= addr_err_d;
            conflict_q <= conflict_d;
            if (clr_count) begin
                count_q <= '0;
            end else if (err_any_d && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign data_out    = data_out_q;
    assign rd_valid    = rd_valid_q;
    assign par_err     = par_err_q;
    assign uninit      = uninit_q;
    assign addr_err    = addr_err_q;
    assign conflict    = conflict_q;
    assign error_count = count_q;

endmodule
